// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Definitions shared by the UART TX/RX buffering blocks.
//               Holds the launch FSM state encoding and the default
//               payload width.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default payload width. Kept equal to the uart_tx PAYLOAD_BITS.
  localparam int unsigned UART_DATA_BITS = 8;

  // Launch FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO built from a register array. It has
//               separate read/write pointers that wrap modulo DEPTH and an
//               explicit occupancy counter. The full and empty flags are
//               decoded from the counter only, so they have no
//               combinational path from push or pop.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               push         - write request (dropped when full or flushing)
//               wr_data      - data to write
//               pop          - read request (ignored when empty or flushing)
//               flush        - synchronous clear of all queued entries
//               rd_data      - head entry (valid while !empty)
//               full, empty  - occupancy flags
//               level        - occupancy count, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int unsigned DEPTH = 16,  // power of two, >= 2
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;

  // A flush wins over both push and pop in the same cycle. A pop does not
  // make room for a push in the same cycle, because full is a registered
  // state flag.
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  assign rd_data = r_mem[r_rd_ptr];

  // The storage has no reset. Entries are only read after they are written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte queue between the mem_ctl UART TX register path and the
//               uart_tx serializer. Queued bytes are launched one frame at a
//               time over the uart_tx en/busy handshake.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               wr_en/wr_data - push request and byte from mem_ctl
//               flush         - drop all queued (not yet launched) bytes
//               full, empty   - queue flags
//               level         - queued byte count, 0..DEPTH
//               idle          - drain complete (empty, FSM idle, busy low)
//               uart_tx_en    - one-cycle launch pulse to uart_tx
//               uart_tx_data  - launched byte, held until the next launch
//               uart_tx_busy  - serializer busy
//               overflow      - sticky dropped-push flag    (stats build)
//               tx_count      - wrapping launched-frame count (stats build)
// Options     : define UART_TX_FIFO_STATS_EN to add overflow and tx_count.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DATA_BITS = UART_DATA_BITS,
  parameter int unsigned BUSY_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle,
  output logic                   uart_tx_en,
  output logic [DATA_BITS-1:0]   uart_tx_data,
  input  logic                   uart_tx_busy
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic                   overflow,
  output logic [15:0]            tx_count
`endif
);

  localparam int unsigned CW = $clog2(BUSY_WAIT) + 1;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [CW-1:0]        r_wait_cnt;
  logic [DATA_BITS-1:0] r_data_hold;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_launch;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (w_launch),
    .flush   (flush),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level)
  );

  assign full  = w_full;
  assign empty = w_empty;

  // State register, wait counter and launched-byte hold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_data_hold <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_launch) begin
        r_wait_cnt  <= '0;
        r_data_hold <= w_head;
      end else if (r_state == ST_WAIT_HI && !uart_tx_busy) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_next_state = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        // Fall back to IDLE if busy never rises, so a missed handshake
        // cannot stall the queue.
        if (uart_tx_busy) begin
          w_next_state = ST_WAIT_LO;
        end else if (r_wait_cnt == CW'(BUSY_WAIT - 1)) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT_LO: begin
        if (!uart_tx_busy) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic. The launch is decided in the same cycle that the head
  // becomes visible. The head is forwarded straight to uart_tx_data on that
  // cycle, which gives one-cycle push-to-launch latency without bypassing
  // storage. A same-cycle flush blocks the pop.
  always_comb begin
    w_launch     = (r_state == ST_IDLE) && !w_empty && !uart_tx_busy && !flush;
    uart_tx_en   = w_launch;
    uart_tx_data = w_launch ? w_head : r_data_hold;
    idle         = w_empty && (r_state == ST_IDLE) && !uart_tx_busy;
  end

`ifdef UART_TX_FIFO_STATS_EN
  logic        r_overflow;
  logic [15:0] r_tx_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_tx_count <= '0;
    end else begin
      if (flush) begin
        r_overflow <= 1'b0;
      end else if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_launch) begin
        r_tx_count <= r_tx_count + 16'd1;
      end
    end
  end

  assign overflow = r_overflow;
  assign tx_count = r_tx_count;
`endif

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo. The bench
//               drives uart_tx_busy by hand to stand in for the serializer.
// Options     : define UART_TX_FIFO_STATS_EN to also check overflow/tx_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       idle;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
`ifdef UART_TX_FIFO_STATS_EN
  logic        overflow;
  logic [15:0] tx_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_fifo #(
    .DEPTH     (DEPTH),
    .DATA_BITS (8),
    .BUSY_WAIT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .idle         (idle),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy)
`ifdef UART_TX_FIFO_STATS_EN
    ,
    .overflow     (overflow),
    .tx_count     (tx_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Release busy, wait (bounded) for a launch and check the byte. Optionally
  // push a byte in the launch cycle. Then play one serializer frame:
  // busy high for hi_cycles, then low again.
  task automatic serve_frame(input logic [7:0] exp, input bit push_en,
                             input logic [7:0] pbyte, input int hi_cycles);
    int waited;
    waited       = 0;
    uart_tx_busy = 1'b0;
    #1;
    while (!uart_tx_en && waited < 20) begin
      tick();
      #1;
      waited++;
    end
    check("launch_seen", {31'd0, uart_tx_en}, 32'd1);
    check("launch_data", {24'd0, uart_tx_data}, {24'd0, exp});
    if (push_en) begin
      wr_en   = 1'b1;
      wr_data = pbyte;
    end
    tick();
    wr_en        = 1'b0;
    uart_tx_busy = 1'b1;
    for (int k = 0; k < hi_cycles; k++) begin
      #1;
      check("no_en_while_busy", {31'd0, uart_tx_en}, 32'd0);
      tick();
    end
    uart_tx_busy = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    flush        = 1'b0;
    uart_tx_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // ---- reset state ----
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_en", {31'd0, uart_tx_en}, 32'd0);
    check("rst_data", {24'd0, uart_tx_data}, 32'd0);
    tick();

    // ---- single push 0x41, one-cycle latency ----
    wr_en   = 1'b1;
    wr_data = 8'h41;
    tick();
    wr_en = 1'b0;
    #1;
    check("t1_en", {31'd0, uart_tx_en}, 32'd1);
    check("t1_data", {24'd0, uart_tx_data}, 32'h41);
    tick();
    #1;
    check("t1_en_pulse", {31'd0, uart_tx_en}, 32'd0);
    check("t1_level0", {27'd0, level}, 32'd0);
    check("t1_data_hold", {24'd0, uart_tx_data}, 32'h41);
    check("t1_not_idle", {31'd0, idle}, 32'd0);
    uart_tx_busy = 1'b1;
    tick();
    tick();
    uart_tx_busy = 1'b0;
    #1;
    check("t1_idle_waitlo", {31'd0, idle}, 32'd0);
    tick();
    #1;
    check("t1_idle", {31'd0, idle}, 32'd1);
    tick();

    // ---- fill to full with busy high, overflow push dropped ----
    uart_tx_busy = 1'b1;
    push_burst(8'h00, 16);
    #1;
    check("t2_full", {31'd0, full}, 32'd1);
    check("t2_level16", {27'd0, level}, 32'd16);
    check("t2_no_en", {31'd0, uart_tx_en}, 32'd0);
    tick();
    push_burst(8'hFF, 1);
    #1;
    check("t2_level_drop", {27'd0, level}, 32'd16);
`ifdef UART_TX_FIFO_STATS_EN
    check("t2_overflow", {31'd0, overflow}, 32'd1);
`endif
    tick();
    for (int i = 0; i < 16; i++) begin
      serve_frame(8'(i), 1'b0, 8'h00, 2);
    end
    #1;
    check("t2_empty", {31'd0, empty}, 32'd1);
    check("t2_idle", {31'd0, idle}, 32'd1);
    tick();

    // ---- push+pop at level 5, 40 bytes, pointer wrap ----
    uart_tx_busy = 1'b1;
    push_burst(8'h80, 5);
    #1;
    check("t3_level5", {27'd0, level}, 32'd5);
    tick();
    for (int j = 0; j < 40; j++) begin
      serve_frame(8'h80 + 8'(j), (j < 35), 8'h80 + 8'(j + 5), 1);
      if (j < 35) begin
        check("t3_level_keep", {27'd0, level}, 32'd5);
      end
    end
    check("t3_empty", {31'd0, empty}, 32'd1);
    tick();

    // ---- busy never rises: timeout after 4 wait cycles ----
    uart_tx_busy = 1'b0;
    wr_en        = 1'b1;
    wr_data      = 8'hA1;
    tick();
    wr_data = 8'hB2;
    #1;
    check("t4_en_a", {31'd0, uart_tx_en}, 32'd1);
    check("t4_data_a", {24'd0, uart_tx_data}, 32'hA1);
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_wait_no_en", {31'd0, uart_tx_en}, 32'd0);
      tick();
    end
    #1;
    check("t4_en_b", {31'd0, uart_tx_en}, 32'd1);
    check("t4_data_b", {24'd0, uart_tx_data}, 32'hB2);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_not_idle", {31'd0, idle}, 32'd0);
      tick();
    end
    #1;
    check("t4_idle", {31'd0, idle}, 32'd1);
    tick();

    // ---- flush during WAIT_LO, same-cycle push discarded ----
    uart_tx_busy = 1'b1;
    push_burst(8'h10, 8);
    uart_tx_busy = 1'b0;
    #1;
    check("t5_en", {31'd0, uart_tx_en}, 32'd1);
    check("t5_data", {24'd0, uart_tx_data}, 32'h10);
    tick();
    uart_tx_busy = 1'b1;
    tick();
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h55;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    check("t5_level0", {27'd0, level}, 32'd0);
    check("t5_empty", {31'd0, empty}, 32'd1);
    check("t5_data_hold", {24'd0, uart_tx_data}, 32'h10);
`ifdef UART_TX_FIFO_STATS_EN
    check("t5_overflow_clr", {31'd0, overflow}, 32'd0);
    check("t5_tx_count", {16'd0, tx_count}, 32'd60);
`endif
    tick();
    tick();
    uart_tx_busy = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_no_en", {31'd0, uart_tx_en}, 32'd0);
      check("t5_idle", {31'd0, idle}, 32'd1);
      tick();
    end

    // ---- asynchronous reset mid-frame with level 3 ----
    uart_tx_busy = 1'b1;
    push_burst(8'h20, 4);
    uart_tx_busy = 1'b0;
    #1;
    check("t6_en", {31'd0, uart_tx_en}, 32'd1);
    check("t6_data", {24'd0, uart_tx_data}, 32'h20);
    tick();
    uart_tx_busy = 1'b1;
    tick();
    check("t6_level3", {27'd0, level}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_level", {27'd0, level}, 32'd0);
    check("t6_rst_empty", {31'd0, empty}, 32'd1);
    check("t6_rst_full", {31'd0, full}, 32'd0);
    check("t6_rst_en", {31'd0, uart_tx_en}, 32'd0);
    check("t6_rst_data", {24'd0, uart_tx_data}, 32'd0);
`ifdef UART_TX_FIFO_STATS_EN
    check("t6_rst_tx_count", {16'd0, tx_count}, 32'd0);
`endif
    uart_tx_busy = 1'b0;
    #1;
    check("t6_rst_idle", {31'd0, idle}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_no_en", {31'd0, uart_tx_en}, 32'd0);
      tick();
    end
    push_burst(8'h77, 1);
    #1;
    check("t6_new_en", {31'd0, uart_tx_en}, 32'd1);
    check("t6_new_data", {24'd0, uart_tx_data}, 32'h77);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_tx_fifo
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer between the memory controller's UART TX register path and the uart_tx serializer.
- Decouples CPU stores from the serial bit rate: up to DEPTH bytes are queued, then drained to uart_tx one frame at a time using its en/busy handshake.
- Instantiated in soc between mem_ctl (write side) and uart_tx (read side). mem_ctl polls full/level instead of uart_tx_busy.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2.
- DATA_BITS, 8, payload width; matches uart_tx PAYLOAD_BITS.
- BUSY_WAIT, 4, max cycles to wait for uart_tx_busy to rise after a launch before returning to IDLE.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  push request from mem_ctl, one cycle per byte
- wr_data  input  DATA_BITS  byte to push
- flush  input  1  synchronous clear of queued (not yet launched) bytes
- full  output  1  no free entry
- empty  output  1  no queued entry
- level  output  $clog2(DEPTH)+1  queued entry count, 0..DEPTH
- idle  output  1  empty and FSM in IDLE and uart_tx_busy low (drain complete)
- uart_tx_en  output  1  one-cycle launch pulse to uart_tx
- uart_tx_data  output  DATA_BITS  byte to uart_tx, held stable from launch until the next launch
- uart_tx_busy  input  1  serializer busy

Behaviour:
- Reset values: pointers 0, level 0, full 0, empty 1, idle 1 (given busy low), uart_tx_en 0, uart_tx_data 0, FSM IDLE.
- Storage: DEPTH-entry register array. Read and write pointers are $clog2(DEPTH)-bit and wrap modulo DEPTH. level is a separate counter. full = (level==DEPTH); empty = (level==0). Both flags are registered-state derived, with no combinational path from wr_en.
- Push: accepted iff wr_en && !full && !flush. A push while full is dropped silently; contents and pointers are unchanged. A pop in the same cycle does not make room for a push issued while full.
- Simultaneous push and pop: level unchanged, both pointers advance.
- FSM, IDLE:
  - If !empty && !uart_tx_busy: pop the head into uart_tx_data, pulse uart_tx_en for exactly 1 cycle, load the wait counter with 0, go to WAIT_HI.
- FSM, WAIT_HI:
  - If uart_tx_busy, go to WAIT_LO.
  - Otherwise increment the counter. At BUSY_WAIT-1, go to IDLE; this prevents lockup if busy never rises.
- FSM, WAIT_LO:
  - When !uart_tx_busy, go to IDLE.
  - The next launch comes no earlier than the cycle after IDLE is re-entered.
- Latency: a push at cycle N into an empty FIFO with the FSM in IDLE and busy low gives uart_tx_en high in cycle N+1 with uart_tx_data = that byte. A push does not bypass storage.
- Back-to-back frames: uart_tx_en never asserts while uart_tx_busy is high or while the FSM is in WAIT_HI/WAIT_LO.
- Flush: next cycle, pointers and level are 0 and empty is 1. Flush overrides a same-cycle push. The in-flight byte (already launched) is not aborted, and the FSM continues its wait states normally. A flush during IDLE with a pop-eligible head blocks that pop.
- Reset mid-frame: all state returns to reset values immediately. uart_tx is reset by the same event (inverted rst_n domain in soc).

Optional Feature:
- Macro: UART_TX_FIFO_STATS_EN.
- With it defined:
  - Adds output overflow (1 bit, sticky): set on any dropped push, cleared by flush or rst.
  - Adds output tx_count (16 bits): frames launched, wraps at 65535->0, cleared only by rst.
- Without it: neither port nor its logic exists, and dropped pushes are not recorded.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding localparams ST_IDLE, ST_WAIT_HI, ST_WAIT_LO.
  - UART_DATA_BITS = 8.
- Sub-module: one natural sub-module, sync_fifo, holding the storage, pointers, level and flags with push/pop/flush. It is reusable later for the UART RX path.
- The launch FSM stays in uart_tx_fifo.

Test Plan:
- Single push 0x41 with FIFO empty, busy low -> uart_tx_en high exactly one cycle later, uart_tx_data=0x41, level returns to 0, idle rises after busy falls.
- Push 16 bytes 0x00..0x0F back-to-back with busy held high -> full=1, level=16. A 17th push of 0xFF is dropped (overflow=1 when STATS_EN). Release busy -> bytes emitted in order 0x00..0x0F, one uart_tx_en per busy low period.
- Push and pop in the same cycle at level=5 -> level stays 5, pointer wrap exercised by 40 total bytes at DEPTH=16, order preserved.
- After launch, hold busy low -> FSM returns to IDLE after BUSY_WAIT=4 cycles, next byte launched, no hang.
- Queue 8 bytes, flush during a WAIT_LO frame -> in-flight byte completes, level=0 next cycle, no further uart_tx_en. Same-cycle wr_en 0x55 discarded.
- Assert rst mid-frame with level=3 -> all outputs at reset values asynchronously, no uart_tx_en after release until a new push.
